// File: rtl/dram_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dram_fifo_pkg
// Brief   : Shared constants, pointer type and full test for dram_fifo32.
// Revision: 1.0 - initial release
// ============================================================================

package dram_fifo_pkg;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned ABITS = 5;

  // Extra MSB distinguishes a full FIFO from an empty one at equal addresses.
  typedef logic [ABITS:0] ptr_t;

  function automatic logic ptr_full(input ptr_t wr, input ptr_t rd);
    return (wr[ABITS] != rd[ABITS]) && (wr[ABITS-1:0] == rd[ABITS-1:0]);
  endfunction

  function automatic logic ptr_empty(input ptr_t wr, input ptr_t rd);
    return (wr == rd);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram32xw.sv
`default_nettype none
// ============================================================================
// Module  : ram32xw
// Brief   : WIDTH/2 parallel RAM32M-style 32x2 columns, write on port D,
//           asynchronous read on port A (B/C share the read address, unused).
// Revision: 1.0 - initial release
// ============================================================================

module ram32xw
  import dram_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8
)(
  input  logic             clk,
  input  logic             i_we,
  input  logic [ABITS-1:0] i_addrd,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [ABITS-1:0] i_addra,
  output logic [WIDTH-1:0] o_rdata
);

  localparam int unsigned c_cols = WIDTH / 2;

  genvar g;
  generate
    for (g = 0; g < c_cols; g++) begin : g_col
      logic [1:0] r_mem [DEPTH];

      // Distributed RAM: no reset, contents survive FIFO reset.
      always_ff @(posedge clk) begin
        if (i_we) begin
          r_mem[i_addrd] <= i_wdata[2*g +: 2];
        end
      end

      assign o_rdata[2*g +: 2] = r_mem[i_addra];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/dram_fifo32.sv
`default_nettype none
// ============================================================================
// Module  : dram_fifo32
// Brief   : 32-deep synchronous FIFO over distributed RAM with registered
//           flags and output. DRAM_FIFO_LEVEL_EN adds level_o / afull_o.
// Revision: 1.0 - initial release
// ============================================================================

module dram_fifo32
  import dram_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ABITS = 5,
  parameter int unsigned AFULL = 28
)(
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             write_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  input  logic             read_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             empty_o
`ifdef DRAM_FIFO_LEVEL_EN
  ,
  output logic [ABITS:0]   level_o,
  output logic             afull_o
`endif
);

  generate
    if (ABITS != 5) begin : g_abits_check
      $error("dram_fifo32: ABITS must be 5");
    end
    if ((WIDTH % 2) != 0 || WIDTH == 0) begin : g_width_check
      $error("dram_fifo32: WIDTH must be even and non-zero");
    end
    if (AFULL > DEPTH) begin : g_afull_check
      $error("dram_fifo32: AFULL exceeds depth");
    end
  endgenerate

  ptr_t             r_wr_ptr;
  ptr_t             r_rd_ptr;
  ptr_t             w_wr_next;
  ptr_t             w_rd_next;
  logic             r_full;
  logic             r_empty;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_rdata;
  logic             w_push;
  logic             w_pop;

  // Requests against a registered blocking flag are simply dropped.
  assign w_push    = write_i & ~r_full;
  assign w_pop     = read_i & ~r_empty;
  assign w_wr_next = r_wr_ptr + ptr_t'(w_push);
  assign w_rd_next = r_rd_ptr + ptr_t'(w_pop);

  ram32xw #(
    .WIDTH (WIDTH)
  ) u_ram (
    .clk     (clock_i),
    .i_we    (w_push),
    .i_addrd (r_wr_ptr[ABITS-1:0]),
    .i_wdata (data_i),
    .i_addra (r_rd_ptr[ABITS-1:0]),
    .o_rdata (w_rdata)
  );

  // Flags come from next-state pointers so they are exact in the cycle after.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_valid  <= 1'b0;
      r_data   <= '0;
    end else begin
      r_wr_ptr <= w_wr_next;
      r_rd_ptr <= w_rd_next;
      r_full   <= ptr_full(w_wr_next, w_rd_next);
      r_empty  <= ptr_empty(w_wr_next, w_rd_next);
      r_valid  <= w_pop;
      if (w_pop) begin
        r_data <= w_rdata;
      end
    end
  end

  assign full_o  = r_full;
  assign empty_o = r_empty;
  assign valid_o = r_valid;
  assign data_o  = r_data;

`ifdef DRAM_FIFO_LEVEL_EN
  typedef logic [ABITS:0] level_t;
  localparam level_t c_afull = level_t'(AFULL);

  level_t r_level;
  level_t w_level_next;
  logic   r_afull;

  always_comb begin
    w_level_next = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_next = r_level + level_t'(1);
      2'b01:   w_level_next = r_level - level_t'(1);
      default: w_level_next = r_level;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_level <= '0;
      r_afull <= 1'b0;
    end else begin
      r_level <= w_level_next;
      r_afull <= (w_level_next >= c_afull);
    end
  end

  assign level_o = r_level;
  assign afull_o = r_afull;
`endif

endmodule

`default_nettype wire
